// File: rtl/lf_cmd_pkg.sv
// Shared definitions for the LF configuration command SPI master: opcodes,
// FSM encoding and the 16-bit command word layout.
package lf_cmd_pkg;

  localparam logic [3:0] CMD_SET_CONF       = 4'b0001;
  localparam logic [3:0] CMD_SET_DIVISOR    = 4'b0010;
  localparam logic [3:0] CMD_SET_USER_BYTE1 = 4'b0011;

  localparam int FIFO_DEPTH = 4;
  localparam int ENTRY_W    = 12;
  localparam int WORD_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == CMD_SET_CONF) || (op == CMD_SET_DIVISOR) ||
           (op == CMD_SET_USER_BYTE1);
  endfunction

  // The FIFO holds only {op, data}; the zero nibble is reinserted here.
  function automatic logic [WORD_W-1:0] pack_word(input logic [3:0] op,
                                                  input logic [7:0] data);
    return {op, 4'b0000, data};
  endfunction

endpackage

// File: rtl/lf_cmd_fifo.sv
// 4-entry first-word-fall-through command FIFO; rd_data always shows the
// oldest entry while empty is low.
module lf_cmd_fifo
  import lf_cmd_pkg::*;
(
  input  logic               pck0,
  input  logic               nreset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [2:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == 3'(FIFO_DEPTH));
  assign empty   = (count_q == 3'd0);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {1'b0, do_push};
    rd_ptr_d = rd_ptr_q + {1'b0, do_pop};
    count_d  = count_q + {2'b00, do_push} - {2'b00, do_pop};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count make
  // stale contents unreachable, and a reset would block RAM inference.
  always_ff @(posedge pck0) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/lf_spi_cmd_tx.sv
// SPI master that queues host commands and shifts them out as 16-bit words
// on spck/mosi/ncs, capturing miso into a readback word per transfer.
module lf_spi_cmd_tx
  import lf_cmd_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int NCS_IDLE = 4
) (
  input  logic        pck0,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        spck,
  output logic        mosi,
  output logic        ncs,
  input  logic        miso,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        err_op
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("lf_spi_cmd_tx: CLK_DIV must be in 1..255");
  end
  if (NCS_IDLE < 1 || NCS_IDLE > 255) begin : g_bad_ncs_idle
    $error("lf_spi_cmd_tx: NCS_IDLE must be in 1..255");
  end

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(NCS_IDLE - 1);

  state_e             state_q, state_d;
  logic [7:0]         phase_q, phase_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               last_q, last_d;
  logic [WORD_W-1:0]  tx_sr_q, tx_sr_d;
  logic [WORD_W-1:0]  rx_sr_q, rx_sr_d;
  logic [WORD_W-1:0]  rx_data_q, rx_data_d;
  logic               spck_q, spck_d;
  logic               mosi_q, mosi_d;
  logic               ncs_q, ncs_d;
  logic               rx_valid_q, rx_valid_d;
  logic               err_op_q, err_op_d;

  logic               cmd_hs, fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty, phase_done;
  logic [ENTRY_W-1:0] fifo_rd;

  assign cmd_ready = !fifo_full;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign fifo_push = cmd_hs && op_legal(cmd_op);
  assign phase_done = (phase_q == 8'd0);

  lf_cmd_fifo u_fifo (
    .pck0    (pck0),
    .nreset  (nreset),
    .push    (fifo_push),
    .wr_data ({cmd_op, cmd_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    spck_d     = spck_q;
    mosi_d     = mosi_q;
    ncs_d      = ncs_q;
    rx_valid_d = 1'b0;
    err_op_d   = cmd_hs && !op_legal(cmd_op);
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d   = ST_SETUP;
          fifo_pop  = 1'b1;
          tx_sr_d   = pack_word(fifo_rd[11:8], fifo_rd[7:0]);
          mosi_d    = tx_sr_d[WORD_W-1];
          ncs_d     = 1'b0;
          phase_d   = DIV_LAST;
          bit_cnt_d = 4'd15;
          last_d    = 1'b0;
        end
      end

      ST_SETUP: begin
        if (phase_done) begin
          state_d = ST_HIGH;
          spck_d  = 1'b1;
          rx_sr_d = {rx_sr_q[WORD_W-2:0], miso};
          phase_d = DIV_LAST;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      ST_HIGH: begin
        if (phase_done) begin
          state_d = ST_LOW;
          spck_d  = 1'b0;
          phase_d = DIV_LAST;
          // bit_cnt tracks the bit on mosi; once bit 0 has been clocked the
          // LOW phase now starting is the final one of the word.
          if (bit_cnt_q != 4'd0) begin
            bit_cnt_d = bit_cnt_q - 4'd1;
            mosi_d    = tx_sr_q[WORD_W-2];
            tx_sr_d   = {tx_sr_q[WORD_W-2:0], 1'b0};
          end else begin
            last_d = 1'b1;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      ST_LOW: begin
        if (phase_done) begin
          if (last_q) begin
            state_d    = ST_GAP;
            ncs_d      = 1'b1;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            phase_d    = GAP_LAST;
          end else begin
            state_d = ST_HIGH;
            spck_d  = 1'b1;
            rx_sr_d = {rx_sr_q[WORD_W-2:0], miso};
            phase_d = DIV_LAST;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      ST_GAP: begin
        if (phase_done) begin
          state_d = ST_IDLE;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ncs_d   = 1'b1;
        spck_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      spck_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ncs_q      <= 1'b1;
      rx_valid_q <= 1'b0;
      err_op_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      spck_q     <= spck_d;
      mosi_q     <= mosi_d;
      ncs_q      <= ncs_d;
      rx_valid_q <= rx_valid_d;
      err_op_q   <= err_op_d;
    end
  end

  assign spck     = spck_q;
  assign mosi     = mosi_q;
  assign ncs      = ncs_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign err_op   = err_op_q;
  assign busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_lf_spi_cmd_tx.sv
// Scoreboard bench for lf_spi_cmd_tx: stimulus queues expected words, a
// monitor reassembles each ncs-framed word from mosi and compares.
module tb_lf_spi_cmd_tx;

  logic        pck0 = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_data = '0;
  logic        spck, mosi, ncs, miso;
  logic [15:0] rx_data;
  logic        rx_valid, busy, err_op;
  logic        loopback = 1'b0;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] rx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_words = 0;

  // monitor state, visible to stimulus for synchronisation
  logic        prev_ncs = 1'b1, prev_spck = 1'b0;
  logic        in_word = 1'b0, seen_rise = 1'b0, chk_gap = 1'b0;
  int          low_cnt = 0, gap_cnt = 0, edges = 0;
  logic [15:0] word_sh = '0;

  assign miso = loopback ? mosi : 1'b1;

  always #5 pck0 = ~pck0;

  lf_spi_cmd_tx #(.CLK_DIV(4), .NCS_IDLE(4)) dut (
    .pck0      (pck0),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .spck      (spck),
    .mosi      (mosi),
    .ncs       (ncs),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .err_op    (err_op)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling pck0 edge, away from DUT updates.
  always @(negedge pck0) begin
    if (!nreset) begin
      in_word   = 1'b0;
      edges     = 0;
      prev_ncs  = 1'b1;
      prev_spck = 1'b0;
    end else begin
      if (prev_ncs && !ncs) begin
        if (chk_gap && seen_rise) check("ncs_gap", 32'(gap_cnt), 32'd5);
        in_word = 1'b1;
        low_cnt = 0;
        edges   = 0;
        word_sh = '0;
        gap_cnt = 0;
      end
      if (!ncs) low_cnt++;
      else      gap_cnt++;
      if (!prev_spck && spck) begin
        word_sh = {word_sh[14:0], mosi};
        edges++;
      end
      if (rx_valid || (!prev_ncs && ncs))
        check("rx_valid_with_ncs_rise", 32'(rx_valid), 32'(!prev_ncs && ncs));
      if (!prev_ncs && ncs) begin
        if (exp_q.size() == 0) begin
          check("word_expected", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mosi_word", 32'(word_sh), 32'(e.word));
          check("spck_rises", 32'(edges), 32'd16);
          check("ncs_low_cycles", 32'(low_cnt), 32'd132);
          check("rx_data", 32'(rx_data), 32'(e.rx));
        end
        n_words++;
        in_word   = 1'b0;
        seen_rise = 1'b1;
        gap_cnt   = 1;
      end
      prev_ncs  = ncs;
      prev_spck = spck;
    end
  end

  // Present one command for one cycle; called just after a falling edge and
  // returns just after the next one. acc is the handshake outcome.
  task automatic drive(input logic [3:0] op, input logic [7:0] d, output logic acc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    acc       = cmd_ready;
    @(negedge pck0);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge pck0);
      if (!busy) break;
    end
    check(name, 32'(i < budget), 32'd1);
  endtask

  logic [3:0]  b_op   [6] = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3};
  logic [7:0]  b_dat  [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h42};
  logic [15:0] b_word [6] = '{16'h10A5, 16'h203C, 16'h30FF, 16'h1000, 16'h2081, 16'h3042};

  initial begin
    logic acc;
    int   n_acc, hi_cnt, lows, i;

    // Reset held for three cycles.
    repeat (3) @(posedge pck0);
    @(negedge pck0);
    check("rst_ncs", 32'(ncs), 32'd1);
    check("rst_spck", 32'(spck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_op", 32'(err_op), 32'd0);
    nreset = 1'b1;
    repeat (2) @(negedge pck0);

    // Single command: miso held high, so readback is all ones.
    exp_q.push_back('{word: 16'h1001, rx: 16'hFFFF});
    drive(4'h1, 8'h01, acc);
    cmd_valid = 1'b0;
    check("single_accept", 32'(acc), 32'd1);
    check("single_busy_t1", 32'(busy), 32'd1);
    check("single_ncs_t1", 32'(ncs), 32'd1);
    @(negedge pck0);
    check("single_ncs_t2", 32'(ncs), 32'd0);
    wait_idle(400, "single_done");
    repeat (3) @(negedge pck0);

    // Burst: six back-to-back commands, only five fit.
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(b_op[k], b_dat[k], acc);
      if (acc) begin
        n_acc++;
        exp_q.push_back('{word: b_word[k], rx: 16'hFFFF});
      end
      if (k == 5) check("burst_ready_6th", 32'(acc), 32'd0);
    end
    cmd_valid = 1'b0;
    chk_gap   = 1'b1;
    check("burst_accepted", 32'(n_acc), 32'd5);
    repeat (100) @(negedge pck0);
    check("burst_ready_still_low", 32'(cmd_ready), 32'd0);
    hi_cnt = 0;
    for (i = 0; i < 2000; i++) begin
      @(negedge pck0);
      if (!busy) break;
      if (ncs) hi_cnt++;
      else     hi_cnt = 0;
    end
    check("burst_done", 32'(i < 2000), 32'd1);
    check("busy_through_last_gap", 32'(hi_cnt), 32'd4);
    check("burst_queue_drained", 32'(exp_q.size()), 32'd0);
    chk_gap = 1'b0;
    repeat (3) @(negedge pck0);

    // Loopback: miso follows mosi, readback equals the sent word.
    loopback = 1'b1;
    exp_q.push_back('{word: 16'h2007, rx: 16'h2007});
    drive(4'h2, 8'h07, acc);
    cmd_valid = 1'b0;
    wait_idle(400, "loopback_done");
    loopback = 1'b0;
    repeat (3) @(negedge pck0);

    // Illegal opcodes: handshake completes, word dropped, err_op pulses.
    drive(4'h5, 8'h33, acc);
    cmd_valid = 1'b0;
    check("illegal_handshake", 32'(acc), 32'd1);
    check("illegal_err_op", 32'(err_op), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    @(negedge pck0);
    check("illegal_err_op_clear", 32'(err_op), 32'd0);
    drive(4'h0, 8'hFF, acc);
    cmd_valid = 1'b0;
    check("zero_op_err_op", 32'(err_op), 32'd1);
    lows = 0;
    repeat (20) begin
      @(negedge pck0);
      if (!ncs || busy) lows++;
    end
    check("illegal_no_transfer", 32'(lows), 32'd0);

    // Reset mid-word with a second command still queued.
    drive(4'h3, 8'hC3, acc);
    drive(4'h1, 8'h55, acc);
    cmd_valid = 1'b0;
    for (i = 0; i < 300; i++) begin
      @(negedge pck0);
      #2;
      if (in_word && edges == 8) break;
    end
    check("midword_reached_8", 32'(i < 300), 32'd1);
    nreset = 1'b0;
    #1;
    check("midrst_ncs", 32'(ncs), 32'd1);
    check("midrst_spck", 32'(spck), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge pck0);
    nreset = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge pck0);
      if (!ncs || busy) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);

    check("words_seen", 32'(n_words), 32'd7);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
